// File: rtl/regfile_dbg_pkg.sv
// Shared types and widths for the register-file debug arbiter.
// Holds the FSM state encoding and the datapath widths.
package regfile_dbg_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int QCNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/regfile_dbg_arbiter.sv
// Shares the register file between the core and a debug port.
// Optional macro REGFILE_DBG_WRITE_EN enables debug writes.
module regfile_dbg_arbiter
    import regfile_dbg_pkg::*;
#(
    parameter int QUIESCE_CYCLES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [REG_ADDR_W-1:0] i_core_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_core_rs2_addr,
    input  logic [REG_ADDR_W-1:0] i_core_rd_addr,
    input  logic [XLEN-1:0]       i_core_rd_data,
    input  logic                  i_core_rd_wren,
    output logic                  o_core_stall,
    output logic [REG_ADDR_W-1:0] o_rf_rs1_addr,
    output logic [REG_ADDR_W-1:0] o_rf_rs2_addr,
    output logic [REG_ADDR_W-1:0] o_rf_rd_addr,
    output logic [XLEN-1:0]       o_rf_rd_data,
    output logic                  o_rf_rd_wren,
    input  logic [XLEN-1:0]       i_rf_rs1_data,
    input  logic                  i_dbg_req_valid,
    output logic                  o_dbg_req_ready,
    input  logic                  i_dbg_req_we,
    input  logic [REG_ADDR_W-1:0] i_dbg_req_addr,
    input  logic [XLEN-1:0]       i_dbg_req_wdata,
    output logic                  o_dbg_rsp_valid,
    input  logic                  i_dbg_rsp_ready,
    output logic [XLEN-1:0]       o_dbg_rsp_rdata,
    output logic                  o_dbg_rsp_err
);

`ifdef REGFILE_DBG_WRITE_EN
    localparam logic WR_EN = 1'b1;
`else
    localparam logic WR_EN = 1'b0;
`endif

    localparam logic [QCNT_W-1:0] QINIT = QCNT_W'(QUIESCE_CYCLES - 1);

    state_t                state_q, state_d;
    logic [QCNT_W-1:0]     qcnt_q, qcnt_d;
    logic                  lat_we;
    logic [REG_ADDR_W-1:0] lat_addr;
    logic [XLEN-1:0]       lat_wdata;
    logic                  stall_q;
    logic                  rsp_valid_q;
    logic [XLEN-1:0]       rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  dbg_wr_acc;
    logic                  dbg_rd_acc;

    // Next-state and quiesce countdown.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_dbg_req_valid) begin
                    state_d = STALL;
                    qcnt_d  = QINIT;
                end
            end
            STALL: begin
                if (qcnt_q == '0) state_d = ACCESS;
                else              qcnt_d  = qcnt_q - QCNT_W'(1);
            end
            ACCESS:  state_d = RESP;
            RESP: begin
                if (i_dbg_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and registered response/stall.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            qcnt_q      <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            stall_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            stall_q     <= (state_d != IDLE);
            rsp_valid_q <= (state_d == RESP);
            if (state_q == IDLE && i_dbg_req_valid) begin
                lat_we    <= i_dbg_req_we;
                lat_addr  <= i_dbg_req_addr;
                lat_wdata <= i_dbg_req_wdata;
            end
            if (state_q == ACCESS) begin
                if (lat_we || lat_addr == '0) rsp_rdata_q <= '0;
                else                          rsp_rdata_q <= i_rf_rs1_data;
                rsp_err_q <= lat_we & ~WR_EN;
            end
        end
    end

    assign dbg_wr_acc = (state_q == ACCESS) && lat_we;
    assign dbg_rd_acc = (state_q == ACCESS) && !lat_we;

    // Register-file port mux: core passthrough unless debug owns it.
    always_comb begin
        o_rf_rs1_addr = i_core_rs1_addr;
        o_rf_rs2_addr = i_core_rs2_addr;
        o_rf_rd_addr  = i_core_rd_addr;
        o_rf_rd_data  = i_core_rd_data;
        o_rf_rd_wren  = 1'b0;
        if (state_q == IDLE) begin
            o_rf_rd_wren = i_core_rd_wren;
        end else if (dbg_wr_acc) begin
            o_rf_rd_addr = lat_addr;
            o_rf_rd_data = lat_wdata;
            o_rf_rd_wren = WR_EN;
        end else if (dbg_rd_acc) begin
            o_rf_rs1_addr = lat_addr;
        end
    end

    assign o_dbg_req_ready = (state_q == IDLE);
    assign o_core_stall    = stall_q;
    assign o_dbg_rsp_valid = rsp_valid_q;
    assign o_dbg_rsp_rdata = rsp_rdata_q;
    assign o_dbg_rsp_err   = rsp_err_q;

endmodule

// File: doc/regfile_dbg_arbiter.md
# regfile_dbg_arbiter

Arbiter that shares the 32×32 register file between the single-cycle core and a debug access port. Sits between core decode/writeback and the register file ports. It freezes the core via a stall, performs one debug read or write on the register file, and returns a response over a valid/ready handshake. Outside debug accesses, core traffic passes straight through.

## Interface
- QUIESCE_CYCLES, default 1: number of stall cycles before the debug access, range 1–15.
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-low.
- i_core_rs1_addr / i_core_rs2_addr  in  5  core read addresses.
- i_core_rd_addr  in  5  core write address.
- i_core_rd_data  in  32  core write data.
- i_core_rd_wren  in  1  core write enable.
- o_core_stall  out  1  freezes PC/fetch; core writeback is gated by this block.
- o_rf_rs1_addr / o_rf_rs2_addr / o_rf_rd_addr  out  5  to register file.
- o_rf_rd_data  out  32  to register file.
- o_rf_rd_wren  out  1  to register file.
- i_rf_rs1_data  in  32  register file rs1 read data.
- i_dbg_req_valid  in  1  debug request valid.
- o_dbg_req_ready  out  1  debug request ready.
- i_dbg_req_we  in  1  1 = write, 0 = read.
- i_dbg_req_addr  in  5  register index.
- i_dbg_req_wdata  in  32  write data.
- o_dbg_rsp_valid  out  1  response valid.
- i_dbg_rsp_ready  in  1  response ready.
- o_dbg_rsp_rdata  out  32  read data; 0 for writes.
- o_dbg_rsp_err  out  1  request rejected.

## Operation
- FSM states:
  - IDLE: o_dbg_req_ready=1. On valid&ready, latch we/addr/wdata, load the quiesce counter with QUIESCE_CYCLES-1, go to STALL.
  - STALL: count down; at 0, go to ACCESS.
  - ACCESS: lasts one cycle.
    - Write: o_rf_rd_addr=latched addr, o_rf_rd_data=latched wdata, o_rf_rd_wren=1.
    - Read: o_rf_rs1_addr=latched addr; capture i_rf_rs1_data into the rdata register at the clock edge.
    - Then go to RESP.
  - RESP: o_dbg_rsp_valid=1; data and err are held stable. On rsp_valid&rsp_ready, go to IDLE.
- o_core_stall=1 in STALL, ACCESS and RESP; 0 in IDLE.
- Passthrough in IDLE: all rf outputs equal the core inputs.
- Outside IDLE:
  - o_rf_rd_wren=0, except for a debug write in ACCESS.
  - rs2 is always passthrough.
  - rs1 is passthrough except in ACCESS for a debug read.
- Write to x0: completes normally with err=0. The register file ignores the write.
- Reads of x0 return 0.
- Request held while not IDLE: ready=0, and the request is not sampled.
- Reset mid-operation, at any state:
  - Next edge goes to IDLE; the latched request is dropped and no response is issued.
  - Any write not yet committed is lost.

## Timing
- Reset values: o_core_stall=0, o_dbg_req_ready=1 after reset (IDLE), o_dbg_rsp_valid=0, o_dbg_rsp_rdata=0, o_dbg_rsp_err=0. rf outputs are passthrough.
- Cycle sequence, with acceptance at edge of cycle 0:
  - Stall is high in cycles 1…QUIESCE_CYCLES+1+R, where R counts RESP cycles.
  - ACCESS is cycle QUIESCE_CYCLES+1.
  - A debug write is visible in the register file from cycle QUIESCE_CYCLES+2.
- o_dbg_rsp_valid first asserts in cycle QUIESCE_CYCLES+2. Minimum request-to-response latency is QUIESCE_CYCLES+2 cycles.
- Back-to-back: next acceptance is possible the cycle after the response handshake. The core gets at least one unstalled cycle between debug accesses.
- o_core_stall, rsp_valid, rdata and err are registered outputs. rf muxing is combinational from state and latched request.

## Configuration
- REGFILE_DBG_WRITE_EN defined: debug writes behave as above.
- REGFILE_DBG_WRITE_EN undefined:
  - Write requests still pass through STALL/ACCESS timing, but o_rf_rd_wren stays 0.
  - Response has o_dbg_rsp_err=1 and rdata=0.
  - Reads are unaffected.

## Structure
- Shared package regfile_dbg_pkg contains:
  - state enum {IDLE, STALL, ACCESS, RESP}
  - REG_ADDR_W=5, XLEN=32
  - quiesce counter width QCNT_W=4
- No sub-module; a single FSM module instantiated beside the register file.

## Test plan
- Idle passthrough: core writes x5=0x0000_1234 with wren=1, no debug request → register file gets addr 5 and data 0x1234; stall=0.
- Debug read: x7 preloaded to 0xDEAD_BEEF, read req addr 7 with QUIESCE_CYCLES=1 → stall in cycles 1–3, rsp_valid in cycle 3, rdata=0xDEADBEEF, err=0.
- Debug write collision: debug write x3=0xA5A5_A5A5 while core holds wren=1, addr 3, data 0x1111 → core write blocked while stalled; x3 reads back 0xA5A5A5A5.
- Response backpressure: i_dbg_rsp_ready held low 5 cycles → rsp_valid, rdata and stall stay stable; a second request is not accepted until after the handshake.
- Reset in STALL: assert i_reset=0 during STALL of a write to x9 → next cycle IDLE, stall=0, rsp_valid=0, x9 unchanged.
- Macro off: write x4=0x55 → err=1, x4 unchanged, same latency as a read.
